// File: rtl/see_voter_monitor.sv
// rtl/see_voter_monitor.sv - TMR bitwise voter with per-replica mismatch counters and fault event log
// Optional feature macro: SEE_MONITOR_LOG_EN builds the event FIFO, timestamp counter and overflow flag.
module see_voter_monitor #(
  parameter int W     = 32,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4,
  parameter     LABEL = "GENERAL",
  localparam int BW   = (W > 1) ? $clog2(W) : 1
) (
  input  logic             s_clk_i,
  input  logic             s_rst_i,
  input  logic             s_valid_i,
  input  logic [W-1:0]     s_d_i [3],
  input  logic             s_clr_i,
  output logic [W-1:0]     s_d_o,
  output logic             s_valid_o,
  output logic             s_err_o,
  output logic [CNT_W-1:0] s_cnt_o [3],
  output logic             s_evt_valid_o,
  input  logic             s_evt_ready_i,
  output logic [2:0]       s_evt_mask_o,
  output logic [BW-1:0]    s_evt_bit_o,
  output logic [15:0]      s_evt_time_o,
  output logic             s_ovf_o
);

  // The label only tags simulation messages; it has no hardware meaning.
  localparam int unused_label_w = $bits(LABEL);

  logic [W-1:0]     maj;
  logic [2:0]       mis;
  logic             err;
  logic [W-1:0]     d_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  // Majority vote and per-replica disagreement; mismatches only count on valid cycles
  always_comb begin
    maj = (s_d_i[0] & s_d_i[1]) | (s_d_i[1] & s_d_i[2]) | (s_d_i[0] & s_d_i[2]);
    mis = '0;
    if (s_valid_i) begin
      for (int k = 0; k < 3; k++) begin
        mis[k] = |(s_d_i[k] ^ maj);
      end
    end
    err = |mis;
  end

  // Registered vote outputs; these keep updating even while a clear is applied
  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      d_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      d_q     <= maj;
      valid_q <= s_valid_i;
      err_q   <= err;
    end
  end

  // Saturating counter next state; a clear wins over a same-cycle mismatch
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
      if (s_clr_i) begin
        cnt_d[k] = '0;
      end else if (mis[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge s_clk_i) begin
    for (int k = 0; k < 3; k++) begin
      if (s_rst_i) cnt_q[k] <= '0;
      else         cnt_q[k] <= cnt_d[k];
    end
  end

  assign s_d_o     = d_q;
  assign s_valid_o = valid_q;
  assign s_err_o   = err_q;
  assign s_cnt_o   = cnt_q;

`ifdef SEE_MONITOR_LOG_EN
  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 3 + BW + 16;

  logic [15:0]      tstamp_q;
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic             ovf_q;
  logic [W-1:0]     diff;
  logic [BW-1:0]    first_bit;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [REC_W-1:0] head;

  // Lowest bit index where the three replicas are not unanimous
  always_comb begin
    diff      = (s_d_i[0] ^ s_d_i[1]) | (s_d_i[1] ^ s_d_i[2]);
    first_bit = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (diff[i]) first_bit = BW'(i);
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // An empty FIFO presents no valid head, so a pop there is naturally ignored
  assign pop   = !empty && s_evt_ready_i;
  // A pop on a full FIFO frees the slot the new record lands in
  assign push  = err && !s_clr_i && (!full || pop);
  assign drop  = err && !s_clr_i && full && !pop;

  // Free-running cycle timestamp, wraps naturally at 16 bits
  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) tstamp_q <= '0;
    else         tstamp_q <= tstamp_q + 16'd1;
  end

  // FIFO pointers and sticky overflow; clear and reset both discard pending events
  always_ff @(posedge s_clk_i) begin
    if (s_rst_i || s_clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) ovf_q    <= 1'b1;
    end
  end

  // Event storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge s_clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {mis, first_bit, tstamp_q};
  end

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign s_evt_valid_o = !empty;
  assign s_evt_mask_o  = empty ? 3'b000 : head[REC_W-1 -: 3];
  assign s_evt_bit_o   = empty ? '0 : head[16 +: BW];
  assign s_evt_time_o  = empty ? 16'd0 : head[15:0];
  assign s_ovf_o       = ovf_q;
`else
  logic unused_evt_ready;
  assign unused_evt_ready = s_evt_ready_i;

  assign s_evt_valid_o = 1'b0;
  assign s_evt_mask_o  = 3'b000;
  assign s_evt_bit_o   = '0;
  assign s_evt_time_o  = 16'd0;
  assign s_ovf_o       = 1'b0;
`endif

endmodule
